s_to_p_flex: RTL and testbench

S_TO_P_FLEX -- requirements
Module: s_to_p_flex

---
 rtl/s_to_p_flex_if.sv | 29 ++
 rtl/s_to_p_flex.sv | 79 +++++++
 tb/tb_s_to_p_flex.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/s_to_p_flex_if.sv
// Beat-in / word-out handshake bundle for s_to_p_flex; S_TO_P_FLEX_LAST_EN adds last_a and cnt_b.
// master = upstream/downstream environment, slave = the converter.
interface s_to_p_flex_if #(
    parameter int DATA_W = 6,
    parameter int IN_W   = 1
);
    logic              valid_a;
    logic [IN_W-1:0]   data_a;
    logic              ready_a;
    logic              valid_b;
    logic              ready_b;
    logic [DATA_W-1:0] data_b;

`ifdef S_TO_P_FLEX_LAST_EN
    localparam int CNT_B_W = $clog2(DATA_W / IN_W + 1);
    logic               last_a;
    logic [CNT_B_W-1:0] cnt_b;

    modport master (output valid_a, data_a, last_a, ready_b,
                    input  ready_a, valid_b, data_b, cnt_b);
    modport slave  (input  valid_a, data_a, last_a, ready_b,
                    output ready_a, valid_b, data_b, cnt_b);
`else
    modport master (output valid_a, data_a, ready_b,
                    input  ready_a, valid_b, data_b);
    modport slave  (input  valid_a, data_a, ready_b,
                    output ready_a, valid_b, data_b);
`endif
endinterface

// File: rtl/s_to_p_flex.sv
// Serial-to-parallel packer: gathers BEATS = DATA_W/IN_W beats into one word (optional early end: S_TO_P_FLEX_LAST_EN).
// Latency: word valid 1 cycle after its final beat is accepted; full throughput, no bubbles.
// Backpressure: only the word-completing beat stalls, while a finished word is still waiting on ready_b.
module s_to_p_flex #(
    parameter int DATA_W    = 6,
    parameter int IN_W      = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    s_to_p_flex_if.slave  bus
);
    localparam int BEATS = DATA_W / IN_W;
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  pos;
    logic [DATA_W-1:0] part;
    logic [DATA_W-1:0] word_nxt;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              fin;
    logic              take;

`ifdef S_TO_P_FLEX_LAST_EN
    localparam int CB_W = $clog2(BEATS + 1);
    logic [CB_W-1:0] cnt_q;
    assign fin       = (cnt == LAST_CNT) || bus.last_a;
    assign bus.cnt_b = cnt_q;
`else
    assign fin = (cnt == LAST_CNT);
`endif

    // The completing beat may only land once the previous word has drained.
    assign bus.ready_a = rst_n && (!fin || !valid_q || bus.ready_b);
    assign take        = bus.valid_a && bus.ready_a;
    assign bus.valid_b = valid_q;
    assign bus.data_b  = data_q;

    always_comb begin
        pos      = (MSB_FIRST != 0) ? (LAST_CNT - cnt) : cnt;
        word_nxt = part;
        for (int i = 0; i < BEATS; i++) begin
            if (CNT_W'(i) == pos) begin
                word_nxt[i*IN_W +: IN_W] = bus.data_a;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            part    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
`ifdef S_TO_P_FLEX_LAST_EN
            cnt_q   <= '0;
`endif
        end else if (take && fin) begin
            // part restarts from zero so an early-ended word leaves its tail bits clear.
            data_q  <= word_nxt;
            valid_q <= 1'b1;
            cnt     <= '0;
            part    <= '0;
`ifdef S_TO_P_FLEX_LAST_EN
            cnt_q   <= CB_W'(cnt) + CB_W'(1);
`endif
        end else begin
            if (take) begin
                cnt  <= cnt + CNT_W'(1);
                part <= word_nxt;
            end
            if (valid_q && bus.ready_b) begin
                valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_s_to_p_flex.sv
// Bench for s_to_p_flex: three configurations (6x1 LSB-first, 6x1 MSB-first, 8x2 LSB-first),
// a per-cycle vector table, hand sequences for gaps/reset/early end, and a randomized run against a model.
module tb_s_to_p_flex;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    s_to_p_flex_if #(.DATA_W(6), .IN_W(1)) i0 ();
    s_to_p_flex_if #(.DATA_W(6), .IN_W(1)) i1 ();
    s_to_p_flex_if #(.DATA_W(8), .IN_W(2)) i2 ();

    s_to_p_flex #(.DATA_W(6), .IN_W(1), .MSB_FIRST(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(i0));
    s_to_p_flex #(.DATA_W(6), .IN_W(1), .MSB_FIRST(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1));
    s_to_p_flex #(.DATA_W(8), .IN_W(2), .MSB_FIRST(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(i2));

    int ntest = 0;
    int nfail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntest++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set01(input logic va, input logic d, input logic rb);
        i0.valid_a = va; i0.data_a = d; i0.ready_b = rb;
        i1.valid_a = va; i1.data_a = d; i1.ready_b = rb;
    endtask

    // ---------------- reference model: beats collected in an array, packed on completion
    function automatic int nb(input int id);   return (id == 2) ? 4 : 6; endfunction
    function automatic int inw(input int id);  return (id == 2) ? 2 : 1; endfunction
    function automatic bit msbf(input int id); return (id == 1);         endfunction

    int         mcnt [3];
    int         bt   [3][8];
    logic       mvb  [3];
    logic [7:0] mdb  [3];
    int         mcb  [3];

    task automatic model_step(input int id, input logic va, input logic [7:0] d, input logic rb,
                              input logic lst, input logic ra_a, input logic vb_a,
                              input logic [7:0] db_a, input int cb_a);
        logic fin, ra;
        int   w, slot;
        fin = (mcnt[id] == nb(id) - 1) || lst;
        ra  = !fin || !mvb[id] || rb;
        if (chk_en) begin
            chk($sformatf("rnd%0d_ready_a", id), 32'(ra_a), 32'(ra));
            chk($sformatf("rnd%0d_valid_b", id), 32'(vb_a), 32'(mvb[id]));
            chk($sformatf("rnd%0d_data_b", id), 32'(db_a), 32'(mdb[id]));
`ifdef S_TO_P_FLEX_LAST_EN
            chk($sformatf("rnd%0d_cnt_b", id), 32'(cb_a), 32'(mcb[id]));
`endif
        end
        if (va && ra) begin
            bt[id][mcnt[id]] = int'(d);
            if (fin) begin
                w = 0;
                for (int k = 0; k <= mcnt[id]; k++) begin
                    slot = msbf(id) ? (nb(id) - 1 - k) : k;
                    w += bt[id][k] * (1 << (slot * inw(id)));
                end
                mdb[id]  = 8'(w);
                mvb[id]  = 1'b1;
                mcb[id]  = mcnt[id] + 1;
                mcnt[id] = 0;
            end else begin
                mcnt[id]++;
                if (mvb[id] && rb) mvb[id] = 1'b0;
            end
        end else if (mvb[id] && rb) begin
            mvb[id] = 1'b0;
        end
    endtask

    logic la0, la1, la2;
    int   cb0, cb1, cb2;
`ifdef S_TO_P_FLEX_LAST_EN
    assign la0 = i0.last_a;  assign la1 = i1.last_a;  assign la2 = i2.last_a;
    assign cb0 = int'(i0.cnt_b); assign cb1 = int'(i1.cnt_b); assign cb2 = int'(i2.cnt_b);
`else
    assign la0 = 1'b0; assign la1 = 1'b0; assign la2 = 1'b0;
    assign cb0 = 0;    assign cb1 = 0;    assign cb2 = 0;
`endif

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int id = 0; id < 3; id++) begin
                mcnt[id] = 0; mvb[id] = 1'b0; mdb[id] = 8'h00; mcb[id] = 0;
            end
        end else begin
            model_step(0, i0.valid_a, 8'(i0.data_a), i0.ready_b, la0, i0.ready_a, i0.valid_b, 8'(i0.data_b), cb0);
            model_step(1, i1.valid_a, 8'(i1.data_a), i1.ready_b, la1, i1.ready_a, i1.valid_b, 8'(i1.data_b), cb1);
            model_step(2, i2.valid_a, 8'(i2.data_a), i2.ready_b, la2, i2.ready_a, i2.valid_b, 8'(i2.data_b), cb2);
        end
    end

    // ---------------- vector table: inputs applied in a cycle, outputs seen in that cycle
    typedef struct {
        logic       va, d, rb, ra, vb;
        logic [5:0] db0, db1;
    } vec_t;
    vec_t tbl [23];

    function automatic vec_t mk(input logic va, input logic d, input logic rb, input logic ra,
                                input logic vb, input logic [5:0] a, input logic [5:0] b);
        vec_t v;
        v.va = va; v.d = d; v.rb = rb; v.ra = ra; v.vb = vb; v.db0 = a; v.db1 = b;
        return v;
    endfunction

    initial begin
        logic [1:0] gb [4];

        // word 0: 1,0,1,1,0,0 drained immediately
        tbl[0]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'h00, 6'h00);
        tbl[1]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'h00, 6'h00);
        tbl[2]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'h00, 6'h00);
        tbl[3]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'h00, 6'h00);
        tbl[4]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'h00, 6'h00);
        tbl[5]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'h00, 6'h00);
        tbl[6]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'h0D, 6'h2C);
        tbl[7]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'h0D, 6'h2C);
        // word 1: 0,1,1,0,1,0 with downstream stalled
        tbl[8]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'h0D, 6'h2C);
        tbl[9]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'h0D, 6'h2C);
        tbl[10] = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'h0D, 6'h2C);
        tbl[11] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'h0D, 6'h2C);
        tbl[12] = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'h0D, 6'h2C);
        tbl[13] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'h0D, 6'h2C);
        // word 2: 1,0,0,1,1,(stall),1 -- last beat held until ready_b rises
        tbl[14] = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'h16, 6'h1A);
        tbl[15] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'h16, 6'h1A);
        tbl[16] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'h16, 6'h1A);
        tbl[17] = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'h16, 6'h1A);
        tbl[18] = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'h16, 6'h1A);
        tbl[19] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'h16, 6'h1A);
        tbl[20] = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'h16, 6'h1A);
        tbl[21] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'h39, 6'h27);
        tbl[22] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'h39, 6'h27);

        rst_n = 1'b0;
        set01(1'b0, 1'b0, 1'b1);
        i2.valid_a = 1'b0; i2.data_a = 2'b00; i2.ready_b = 1'b1;
`ifdef S_TO_P_FLEX_LAST_EN
        i0.last_a = 1'b0; i1.last_a = 1'b0; i2.last_a = 1'b0;
`endif
        @(negedge clk);
        chk("rst_ready_a0", 32'(i0.ready_a), 32'd0);
        chk("rst_valid_b0", 32'(i0.valid_b), 32'd0);
        chk("rst_data_b0",  32'(i0.data_b),  32'd0);
        chk("rst_ready_a2", 32'(i2.ready_a), 32'd0);
        chk("rst_valid_b2", 32'(i2.valid_b), 32'd0);
        tick();
        rst_n = 1'b1;

        for (int r = 0; r < 23; r++) begin
            set01(tbl[r].va, tbl[r].d, tbl[r].rb);
            @(negedge clk);
            chk($sformatf("tbl%0d_ready_a", r), 32'(i0.ready_a), 32'(tbl[r].ra));
            chk($sformatf("tbl%0d_valid_b", r), 32'(i0.valid_b), 32'(tbl[r].vb));
            chk($sformatf("tbl%0d_data_b",  r), 32'(i0.data_b),  32'(tbl[r].db0));
            chk($sformatf("tbl%0d_valid_b_msb", r), 32'(i1.valid_b), 32'(tbl[r].vb));
            chk($sformatf("tbl%0d_data_b_msb",  r), 32'(i1.data_b),  32'(tbl[r].db1));
            tick();
        end

        // 8x2 with two idle cycles between beats: 11,10,00,01 -> 0x4B
        gb[0] = 2'b11; gb[1] = 2'b10; gb[2] = 2'b00; gb[3] = 2'b01;
        for (int k = 0; k < 4; k++) begin
            i2.valid_a = 1'b1; i2.data_a = gb[k];
            @(negedge clk);
            chk($sformatf("gap_beat%0d_ready_a", k), 32'(i2.ready_a), 32'd1);
            chk($sformatf("gap_beat%0d_valid_b", k), 32'(i2.valid_b), 32'd0);
            tick();
            i2.valid_a = 1'b0;
            if (k < 3) begin
                for (int g = 0; g < 2; g++) begin
                    @(negedge clk);
                    chk($sformatf("gap_idle%0d_valid_b", k), 32'(i2.valid_b), 32'd0);
                    tick();
                end
            end
        end
        @(negedge clk);
        chk("gap_valid_b", 32'(i2.valid_b), 32'd1);
        chk("gap_data_b",  32'(i2.data_b),  32'h4B);
        tick();
        @(negedge clk);
        chk("gap_valid_b_drop", 32'(i2.valid_b), 32'd0);
        chk("gap_data_b_hold",  32'(i2.data_b),  32'h4B);
        tick();

        // reset mid-word: three zero beats must vanish
        for (int k = 0; k < 3; k++) begin
            set01(1'b1, 1'b0, 1'b1);
            tick();
        end
        set01(1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_ready_a", 32'(i0.ready_a), 32'd0);
        chk("midrst_valid_b", 32'(i0.valid_b), 32'd0);
        chk("midrst_data_b",  32'(i0.data_b),  32'd0);
        chk("midrst_data_b_msb", 32'(i1.data_b), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            set01(1'b1, 1'b1, 1'b1);
            @(negedge clk);
            chk($sformatf("postrst%0d_ready_a", k), 32'(i0.ready_a), 32'd1);
            chk($sformatf("postrst%0d_valid_b", k), 32'(i0.valid_b), 32'd0);
            tick();
        end
        set01(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("postrst_valid_b", 32'(i0.valid_b), 32'd1);
        chk("postrst_data_b",  32'(i0.data_b),  32'h3F);
        chk("postrst_data_b_msb", 32'(i1.data_b), 32'h3F);
        tick();

`ifdef S_TO_P_FLEX_LAST_EN
        // early end after three beats, then a full word
        for (int k = 0; k < 3; k++) begin
            set01(1'b1, 1'b1, 1'b1);
            i0.last_a = (k == 2); i1.last_a = (k == 2);
            tick();
        end
        set01(1'b0, 1'b0, 1'b1);
        i0.last_a = 1'b0; i1.last_a = 1'b0;
        @(negedge clk);
        chk("last_valid_b", 32'(i0.valid_b), 32'd1);
        chk("last_data_b",  32'(i0.data_b),  32'h07);
        chk("last_cnt_b",   32'(i0.cnt_b),   32'd3);
        chk("last_data_b_msb", 32'(i1.data_b), 32'h38);
        chk("last_cnt_b_msb",  32'(i1.cnt_b),  32'd3);
        tick();
        for (int k = 0; k < 6; k++) begin
            set01(1'b1, 1'b1, 1'b1);
            tick();
        end
        set01(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("full_data_b", 32'(i0.data_b), 32'h3F);
        chk("full_cnt_b",  32'(i0.cnt_b),  32'd6);
        tick();
`endif

        // randomized traffic, checked every cycle against the model
        chk_en = 1'b1;
        for (int c = 0; c < 600; c++) begin
            set01(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 2) != 0));
            i2.valid_a = ($urandom_range(0, 3) != 0);
            i2.data_a  = 2'($urandom);
            i2.ready_b = ($urandom_range(0, 2) != 0);
`ifdef S_TO_P_FLEX_LAST_EN
            i0.last_a = ($urandom_range(0, 7) == 0);
            i1.last_a = i0.last_a;
            i2.last_a = ($urandom_range(0, 7) == 0);
`endif
            tick();
        end
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end
endmodule
